// File: rtl/key_event_decoder.sv
// ---------------------------------------------------------------------------
// key_event_decoder
//
// Turns the debounced, active-low key level into single-cycle event pulses
// (press, release, click, long-press, auto-repeat) so downstream control
// logic never has to do its own edge detection or hold timing.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   -> repeat_pulse fires every REPEAT_CYCLES while in LONG
//   undefined -> no repeat counter is built, repeat_pulse is tied low and
//                LONG simply waits for the release
//
// Parameters
//   LONG_CYCLES    hold time (clk cycles) before a press becomes long, >= 2
//   REPEAT_CYCLES  auto-repeat period (clk cycles) once long, >= 1
//   CNT_W          width of hold/repeat counters
//
// Ports
//   clk            system clock, rising edge
//   nrst           asynchronous active-low reset
//   key_n          debounced key level, 0 = pressed, idle 1
//   press_pulse    one cycle when a press is accepted
//   release_pulse  one cycle when an accepted press is released
//   click_pulse    one cycle with release_pulse if the press never went long
//   long_pulse     one cycle when the hold reaches LONG_CYCLES
//   repeat_pulse   one cycle every REPEAT_CYCLES while long
//   held           high while in PRESSED or LONG
//   state_dbg      current FSM state (0 WAIT_REL, 1 IDLE, 2 PRESSED, 3 LONG)
//
// Handshake: none; key_n is a level sampled every rising edge and all
// outputs are registered, each pulse being high for exactly one cycle.
// ---------------------------------------------------------------------------
module key_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       key_n,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       click_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        LONG     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        click_d    = 1'b0;
        long_d     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        repeat_d   = 1'b0;
`endif
        case (state_q)
            // Key may still be held from before reset; wait for it to go up
            // so that no press is reported for it.
            WAIT_REL: begin
                if (key_n) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!key_n) begin
                    state_d    = PRESSED;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end
            end
            PRESSED: begin
                if (key_n) begin
                    // Release takes priority over reaching the threshold.
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    release_d  = 1'b1;
                    click_d    = 1'b1;
                end else if (hold_cnt_q == LONG_M1) begin
                    state_d    = LONG;
                    hold_cnt_d = '0;
                    long_d     = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt_d  = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (key_n) begin
                    // Release takes priority over a repeat tick.
                    state_d   = IDLE;
                    release_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (rep_cnt_q == REP_M1) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = WAIT_REL;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= WAIT_REL;
            hold_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            click_q    <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q  <= '0;
            repeat_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            click_q    <= click_d;
            long_q     <= long_d;
            held_q     <= held_d;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q  <= rep_cnt_d;
            repeat_q   <= repeat_d;
`endif
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign held          = held_q;
    assign state_dbg     = state_q;

`ifdef KEY_AUTOREPEAT_EN
    assign repeat_pulse = repeat_q;
`else
    // Repeat period is meaningless without the repeat counter.
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^REP_M1;
    assign repeat_pulse   = 1'b0;
`endif

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumer of the debounced, active-low key level produced by the key debouncer. Classifies each press into single-cycle event pulses: press, release, short click, long-press and optional auto-repeat. The DDS control logic uses these pulses to step frequency/phase settings without doing its own edge or timing logic.

## Interface
- LONG_CYCLES, 25000000 — hold time in clk cycles before a press becomes a long press (0.5 s at 50 MHz); must be ≥ 2
- REPEAT_CYCLES, 5000000 — auto-repeat period in clk cycles once long (0.1 s at 50 MHz); must be ≥ 1
- CNT_W, 32 — width of the hold and repeat counters; must hold LONG_CYCLES and REPEAT_CYCLES
- clk  input  1  system clock; all state updates on the rising edge
- nrst  input  1  reset, asynchronous, active-low
- key_n  input  1  debounced key level, 0 = pressed, idle 1; the debouncer updates it on the falling edge, so it is stable at the rising edge
- press_pulse  output  1  one cycle on a press being accepted
- release_pulse  output  1  one cycle on every release of an accepted press
- click_pulse  output  1  one cycle on release when held < LONG_CYCLES
- long_pulse  output  1  one cycle when hold reaches LONG_CYCLES
- repeat_pulse  output  1  one cycle per REPEAT_CYCLES while long
- held  output  1  high while the state is PRESSED or LONG

## Operation
- States: WAIT_REL, IDLE, PRESSED, LONG. Reset enters WAIT_REL.
- WAIT_REL: ignore key_n = 0; key_n = 1 → IDLE. Prevents a spurious press when the key is held through reset.
- IDLE: key_n = 0 → PRESSED, hold_cnt ← 0, press_pulse.
- PRESSED: key_n = 1 → IDLE, release_pulse + click_pulse. Else hold_cnt + 1. When hold_cnt = LONG_CYCLES − 1 with key_n = 0 → LONG, rep_cnt ← 0, long_pulse.
- LONG: key_n = 1 → IDLE, release_pulse only (no click). Else rep_cnt + 1. At rep_cnt = REPEAT_CYCLES − 1 → repeat_pulse, rep_cnt ← 0.
- Counters never wrap. hold_cnt is only live in PRESSED. rep_cnt is only live in LONG. Both clear on leaving the state.
- All event outputs are registered. At most one of press/long/repeat/release is high in any cycle. click_pulse only accompanies release_pulse.

## Timing
- Reset values: all pulse outputs 0, held 0, state WAIT_REL, counters 0. Asserting nrst mid-press aborts immediately with no release_pulse.
- Let key_n first sample 0 at rising edge E in IDLE. press_pulse and held are high in the cycle after E (latency 1).
- long_pulse rises exactly LONG_CYCLES cycles after press_pulse.
- First repeat_pulse rises REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles.
- Release: key_n first samples 1 at edge R. release_pulse (and click_pulse if applicable) is high in the cycle after R, and held falls in that same cycle.
- Simultaneous events: release wins over the long threshold (result is a click, no long_pulse). Release wins over a repeat tick (no repeat_pulse).
- Minimum press: key_n low for one sample gives press_pulse, then release_pulse + click_pulse in consecutive cycles.

## Configuration
- KEY_AUTOREPEAT_EN defined: repeat behaviour exactly as above.
- KEY_AUTOREPEAT_EN undefined: rep_cnt is not built, repeat_pulse is tied 0, and the LONG state simply waits for release. All other timing is unchanged.

## Test plan
Bench parameters: LONG_CYCLES = 10, REPEAT_CYCLES = 4, KEY_AUTOREPEAT_EN defined unless stated.
- Short press: key_n low for 5 cycles → press_pulse at cycle 1; release_pulse + click_pulse 5 cycles later; no long_pulse; held high for 5 cycles.
- Long press: key_n low for 25 cycles → long_pulse 10 cycles after press_pulse; repeat_pulse at +4, +8, +12 after long_pulse; release_pulse without click_pulse.
- Threshold race: key_n low for exactly 10 samples → click_pulse, no long_pulse. Low for 11 samples → long_pulse then release_pulse, no click_pulse.
- Held through reset: key_n = 0 before and after nrst deasserts → no press_pulse until key_n goes 1 then 0 again; all outputs 0 during reset.
- Reset mid-LONG: nrst asserted while in LONG → outputs 0 asynchronously, no release_pulse; state then WAIT_REL.
- Macro off: rerun the long-press scenario → repeat_pulse stays 0 throughout; long_pulse and release_pulse timing identical to the macro-on run.
